// File: rtl/ac_config_sequencer.sv
// ac_config_sequencer
// Power-up and configuration sequencer for the SSM2603 control port.
// Streams a fixed 12-word register init table (with a VMID settle delay
// after R8) to an I2C master over a valid/ready + done handshake. NACKed
// init words are retried a bounded number of times. Once the codec is
// configured, single-word runtime writes from software share the same
// I2C master.
module ac_config_sequencer #(
  parameter int DELAY_CYCLES = 1_000_000,
  parameter int RETRY_MAX    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        i2cValid,
  output logic [15:0] i2cData,
  input  logic        i2cReady,
  input  logic        i2cDone,
  input  logic        i2cNack,
  input  logic        usrReq,
  input  logic [15:0] usrWord,
  output logic        usrGnt,
  output logic        usrErr
);

  // Counter widths; retry counter keeps at least one bit so RETRY_MAX=0 still elaborates.
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES + 1) : 1;

  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY_CYCLES - 1);

  localparam logic [3:0] IDX_PRE_DELAY = 4'd9;   // R8 written, VMID starts charging
  localparam logic [3:0] IDX_ACTIVATE  = 4'd10;  // R9 active, first word after the delay
  localparam logic [3:0] IDX_LAST      = 4'd11;  // R6 outputs on, end of table

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_READY,
    S_U_ISSUE,
    S_U_WAIT,
    S_FAIL
  } state_t;

  state_t          r_state;
  logic [3:0]      r_idx;
  logic [RW-1:0]   r_retry;
  logic [DW-1:0]   r_delay_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic            r_i2c_valid;
  logic [15:0]     r_i2c_data;
  logic            r_usr_gnt;
  logic            r_usr_err;

  logic [15:0]     w_next_word;
  logic            w_start_init;

  // Codec init table: {regAddr[6:0], regData[8:0]}.
  function automatic logic [15:0] f_init_word(input logic [3:0] idx);
    logic [15:0] word;
    case (idx)
      4'd0:    word = 16'h1E00;  // R15 software reset
      4'd1:    word = 16'h0C10;  // R6 power, outputs still off
      4'd2:    word = 16'h0017;  // R0 left line in
      4'd3:    word = 16'h0217;  // R1 right line in
      4'd4:    word = 16'h0479;  // R2 left headphone
      4'd5:    word = 16'h0679;  // R3 right headphone
      4'd6:    word = 16'h0812;  // R4 analog path
      4'd7:    word = 16'h0A00;  // R5 digital path
      4'd8:    word = 16'h0E0A;  // R7 I2S, 24 bit
      4'd9:    word = 16'h1000;  // R8 sample rate
      4'd10:   word = 16'h1201;  // R9 active
      4'd11:   word = 16'h0C00;  // R6 outputs on
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  assign w_next_word  = f_init_word(r_idx + 4'd1);

  // start is honoured only when no init sequence or runtime write is in flight.
  assign w_start_init = start &&
                        ((r_state == S_IDLE) || (r_state == S_READY) || (r_state == S_FAIL));

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_retry     <= '0;
      r_delay_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_i2c_valid <= 1'b0;
      r_i2c_data  <= 16'h0000;
      r_usr_gnt   <= 1'b0;
      r_usr_err   <= 1'b0;
    end else begin
      // Grant/error are single-cycle pulses unless re-asserted below.
      r_usr_gnt <= 1'b0;
      r_usr_err <= 1'b0;

      if (w_start_init) begin
        // (Re)start from the first table word; present it immediately.
        r_state     <= S_ISSUE;
        r_idx       <= 4'd0;
        r_retry     <= '0;
        r_delay_cnt <= '0;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_i2c_valid <= 1'b1;
        r_i2c_data  <= f_init_word(4'd0);
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end

          S_ISSUE: begin
            // Word held stable until the master takes it.
            if (r_i2c_valid && i2cReady) begin
              r_i2c_valid <= 1'b0;
              r_state     <= S_WAIT;
            end
          end

          S_WAIT: begin
            if (i2cDone) begin
              if (!i2cNack) begin
                r_retry <= '0;
                if (r_idx == IDX_PRE_DELAY) begin
                  r_delay_cnt <= '0;
                  r_state     <= S_DELAY;
                end else if (r_idx == IDX_LAST) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_READY;
                end else begin
                  r_idx       <= r_idx + 4'd1;
                  r_i2c_data  <= w_next_word;
                  r_i2c_valid <= 1'b1;
                  r_state     <= S_ISSUE;
                end
              end else if (r_retry < RETRY_LIM) begin
                // Re-issue the same word; i2cData still holds it.
                r_retry     <= r_retry + RW'(1);
                r_i2c_valid <= 1'b1;
                r_state     <= S_ISSUE;
              end else begin
                r_busy  <= 1'b0;
                r_error <= 1'b1;
                r_state <= S_FAIL;
              end
            end
          end

          S_DELAY: begin
            // Exactly DELAY_CYCLES cycles spent here while VMID charges.
            if (r_delay_cnt == DLY_LAST) begin
              r_delay_cnt <= '0;
              r_idx       <= IDX_ACTIVATE;
              r_i2c_data  <= f_init_word(IDX_ACTIVATE);
              r_i2c_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end else begin
              r_delay_cnt <= r_delay_cnt + DW'(1);
            end
          end

          S_READY: begin
            // Runtime writes are only served once the codec is configured.
            if (usrReq) begin
              r_i2c_data  <= usrWord;
              r_i2c_valid <= 1'b1;
              r_state     <= S_U_ISSUE;
            end
          end

          S_U_ISSUE: begin
            if (r_i2c_valid && i2cReady) begin
              r_i2c_valid <= 1'b0;
              r_state     <= S_U_WAIT;
            end
          end

          S_U_WAIT: begin
            // Runtime writes are not retried; the NACK is reported to software.
            if (i2cDone) begin
              r_usr_gnt <= 1'b1;
              r_usr_err <= i2cNack;
              r_state   <= S_READY;
            end
          end

          S_FAIL: begin
            r_state <= S_FAIL;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign i2cValid = r_i2c_valid;
  assign i2cData  = r_i2c_data;
  assign usrGnt   = r_usr_gnt;
  assign usrErr   = r_usr_err;

endmodule

// File: tb/tb_ac_config_sequencer.sv
// Testbench for ac_config_sequencer: I2C master model plus table-driven
// init scenarios and hand-written runtime-write, stall and reset sequences.
module tb_ac_config_sequencer;

  localparam int DLY = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        i2cReady = 1'b1;
  logic        i2cDone = 1'b0;
  logic        i2cNack = 1'b0;
  logic        usrReq = 1'b0;
  logic [15:0] usrWord = 16'h0000;
  logic        busy, done, error, i2cValid, usrGnt, usrErr;
  logic [15:0] i2cData;

  ac_config_sequencer #(.DELAY_CYCLES(DLY), .RETRY_MAX(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .i2cValid(i2cValid), .i2cData(i2cData),
    .i2cReady(i2cReady), .i2cDone(i2cDone), .i2cNack(i2cNack),
    .usrReq(usrReq), .usrWord(usrWord),
    .usrGnt(usrGnt), .usrErr(usrErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Master model configuration (written only by the stimulus process).
  logic [15:0] nack_word = 16'hFFFF;
  int          nack_n = 0;
  logic [15:0] stall_word = 16'hFFFF;
  int          stall_n = 0;

  // Master model state (written only by the master process).
  int          busy_cnt = 0;
  logic [15:0] cur_word = 16'h0000;
  int          nack_used = 0;
  int          stall_seen = 0;
  logic [15:0] acc_log[$];
  int          done1000_edge = -1;
  int          valid1201_cyc = -1;

  logic [15:0] golden [12] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                               16'h0812, 16'h0A00, 16'h0E0A, 16'h1000, 16'h1201, 16'h0C00};

  // I2C master model: accepts on valid&ready, completes 20 cycles later.
  always @(negedge clk) begin
    i2cDone = 1'b0;
    i2cNack = 1'b0;
    if (reset) begin
      busy_cnt = 0;
      i2cReady = 1'b1;
      nack_used = 0;
      stall_seen = 0;
      acc_log.delete();
      done1000_edge = -1;
      valid1201_cyc = -1;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
        if (busy_cnt == 0) begin
          i2cDone = 1'b1;
          if (cur_word == nack_word && nack_used < nack_n) begin
            i2cNack = 1'b1;
            nack_used = nack_used + 1;
          end
          if (cur_word == 16'h1000) done1000_edge = cyc + 1;
        end
      end
      if (i2cValid && i2cData == 16'h1201 && valid1201_cyc < 0) valid1201_cyc = cyc;
      if (i2cValid && busy_cnt == 0 && !i2cDone) begin
        if (i2cData == stall_word && stall_seen < stall_n) begin
          i2cReady = 1'b0;
          stall_seen = stall_seen + 1;
        end else begin
          i2cReady = 1'b1;
          acc_log.push_back(i2cData);
          cur_word = i2cData;
          busy_cnt = 20;
        end
      end else begin
        i2cReady = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int count_word(input logic [15:0] w);
    int n = 0;
    foreach (acc_log[i]) if (acc_log[i] == w) n++;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] nack_word;
    int          nack_n;
    int          exp_acc;
    logic [15:0] cnt_word;
    int          exp_cnt;
    int          exp_0217;
    logic        exp_done;
    logic        exp_error;
  } vec_t;

  initial begin
    vec_t vecs[3];
    bit   ok;
    bit   got;
    logic gerr;
    int   sz;

    vecs[0] = '{16'hFFFF, 0, 12, 16'h0479, 1, 1, 1'b1, 1'b0};
    vecs[1] = '{16'h0479, 2, 14, 16'h0479, 3, 1, 1'b1, 1'b0};
    vecs[2] = '{16'h0017, 4, 6, 16'h0017, 4, 0, 1'b0, 1'b1};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_valid", 32'(i2cValid), 0);
    chk("rst_data", 32'(i2cData), 0);
    chk("rst_gnt", 32'({usrGnt, usrErr}), 0);
    reset = 1'b0;

    // Table-driven init scenarios: clean run, two NACKs, retries exhausted
    for (int r = 0; r < 3; r++) begin
      nack_word = vecs[r].nack_word;
      nack_n = vecs[r].nack_n;
      stall_n = 0;
      do_reset();
      pulse_start();
      wait_end(ok);
      chk($sformatf("v%0d_finished", r), 32'(ok), 1);
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d_accepts", r), acc_log.size(), vecs[r].exp_acc);
      chk($sformatf("v%0d_issues_%h", r, vecs[r].cnt_word), count_word(vecs[r].cnt_word), vecs[r].exp_cnt);
      chk($sformatf("v%0d_issues_0217", r), count_word(16'h0217), vecs[r].exp_0217);
      chk($sformatf("v%0d_done", r), 32'(done), 32'(vecs[r].exp_done));
      chk($sformatf("v%0d_error", r), 32'(error), 32'(vecs[r].exp_error));
      chk($sformatf("v%0d_busy", r), 32'(busy), 0);
      $display("scenario %0d: accepts=%0d done=%0b error=%0b", r, acc_log.size(), done, error);
      if (r == 0) begin
        for (int i = 0; i < 12; i++)
          chk($sformatf("order_%0d", i), (i < acc_log.size()) ? 32'(acc_log[i]) : 32'hDEAD, 32'(golden[i]));
        chk("delay_cycles", valid1201_cyc - done1000_edge, DLY);
      end
    end

    // Runtime write requested during init, with a 7-cycle ready stall on 0812
    nack_n = 0;
    stall_word = 16'h0812;
    stall_n = 7;
    do_reset();
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (acc_log.size() >= 2) break;
    end
    usrWord = 16'h0A08;
    usrReq = 1'b1;
    wait_end(ok);
    chk("usr_init_finished", 32'(ok), 1);
    got = 1'b0;
    gerr = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (usrGnt) begin
        got = 1'b1;
        gerr = usrErr;
        usrReq = 1'b0;
        break;
      end
    end
    sz = acc_log.size();
    chk("usr_gnt", 32'(got), 1);
    chk("usr_err", 32'(gerr), 0);
    chk("usr_accepts", sz, 13);
    chk("usr_word_after_0C00", (sz >= 13) ? 32'({acc_log[11], acc_log[12]}) : 32'hDEAD, 32'h0C000A08);
    @(negedge clk);
    chk("usr_gnt_pulse", 32'(usrGnt), 0);
    chk("usr_done_kept", 32'(done), 1);
    chk("stall_cycles", stall_seen, 7);
    chk("stall_single_accept", count_word(16'h0812), 1);
    $display("runtime write: gnt=%0b err=%0b accepts=%0d stall=%0d", got, gerr, sz, stall_seen);
    stall_n = 0;

    // Reset in the middle of the VMID delay, then restart
    do_reset();
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done1000_edge >= 0) break;
    end
    chk("t6_delay_reached", 32'(done1000_edge >= 0), 1);
    for (int i = 0; i < 200; i++) begin
      if (cyc >= done1000_edge + 50) break;
      @(negedge clk);
    end
    chk("t6_busy_in_delay", 32'({busy, i2cValid}), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_outputs_cleared", 32'({busy, done, error, i2cValid, usrGnt, usrErr}), 0);
    chk("t6_data_cleared", 32'(i2cData), 0);
    reset = 1'b0;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_log.size() >= 1) break;
    end
    chk("t6_restart_word", (acc_log.size() >= 1) ? 32'(acc_log[0]) : 32'hDEAD, 32'h1E00);
    wait_end(ok);
    chk("t6_restart_done", 32'({ok, done, error}), 32'h6);
    $display("reset mid-delay: restart first word=%h done=%0b", (acc_log.size() >= 1) ? acc_log[0] : 16'h0, done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
